// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit and the decoder that drives it.
// Contents:
//   - MD op codes (op port):       MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
//   - HI/LO write codes (we port): MD_WNONE, MD_WHI, MD_WLO
//   - HI/LO read codes (re port):  MD_RNONE, MD_RHI, MD_RLO
//   - helpers classifying an op code
package md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;

  localparam logic [1:0] MD_WNONE = 2'd0;
  localparam logic [1:0] MD_WHI   = 2'd1;
  localparam logic [1:0] MD_WLO   = 2'd2;

  localparam logic [1:0] MD_RNONE = 2'd0;
  localparam logic [1:0] MD_RHI   = 2'd1;
  localparam logic [1:0] MD_RLO   = 2'd2;

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   a, b    : latched operands (WIDTH)
//   op      : latched op code (MD_*)
//   res_hi  : product high half, or remainder
//   res_lo  : product low half, or quotient
//   div0    : op is a divide and b is zero (result must not be committed)
module md_arith
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic                 neg_a;
  logic                 neg_b;
  logic [2*WIDTH-1:0]   mul_a;
  logic [2*WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quo_mag;
  logic [WIDTH-1:0]     rem_mag;

  always_comb begin
    neg_a = md_op_is_signed(op) & a[WIDTH-1];
    neg_b = md_op_is_signed(op) & b[WIDTH-1];

    // Sign- or zero-extending to 2*WIDTH makes a single unsigned multiplier
    // give the correct low 2*WIDTH bits for both signed and unsigned forms.
    mul_a = {{WIDTH{neg_a}}, a};
    mul_b = {{WIDTH{neg_b}}, b};
    prod  = mul_a * mul_b;

    // Signed divide runs on magnitudes. The most-negative dividend has a
    // magnitude that still fits as an unsigned WIDTH value, so
    // most-negative / -1 naturally yields quotient = a and remainder = 0.
    mag_a = neg_a ? (~a) + ONE : a;
    mag_b = neg_b ? (~b) + ONE : b;

    div0    = md_op_is_div(op) && (b == '0);
    // Keep the divider away from a zero divisor; the result is discarded.
    divisor = div0 ? ONE : mag_b;
    quo_mag = mag_a / divisor;
    rem_mag = mag_a % divisor;

    res_hi = '0;
    res_lo = '0;
    if ((op == MD_MULT) || (op == MD_MULTU)) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (md_op_is_div(op)) begin
      // Quotient truncates toward zero; remainder takes the dividend's sign.
      res_lo = (neg_a ^ neg_b) ? (~quo_mag) + ONE : quo_mag;
      res_hi = neg_a ? (~rem_mag) + ONE : rem_mag;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning the HI/LO registers (EX stage).
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   start, op      : launch request and op code (MD_*)
//   src_a, src_b   : rs / rt operands; src_a also supplies mthi/mtlo data
//   we, re         : HI/LO write (MD_WHI/MD_WLO) and read (MD_RHI/MD_RLO)
//   busy           : operation in flight (registered)
//   rd_data        : combinational mfhi/mflo data
//   hi, lo         : current HI/LO
//
// Handshake: a launch is accepted on a rising edge where start=1, busy=0 and
// op is a valid MD op. busy then stays high for exactly MULT_CYCLES or
// DIV_CYCLES cycles; start and we are ignored while busy=1, so upstream must
// stall on busy. HI/LO show the result from the edge that drops busy.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       we,
  input  logic [1:0]       re,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div0;
  logic             launch;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign launch = start && !busy && md_op_valid(op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MD_NONE;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (launch) begin
      a_q  <= src_a;
      b_q  <= src_b;
      op_q <= op;
      cnt  <= md_op_is_div(op) ? CNT_DIV : CNT_MULT;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == CNT_ONE) begin
        cnt  <= '0;
        busy <= 1'b0;
        // Divide by zero leaves HI/LO untouched but still takes full latency.
        if (!div0) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end else if (!start) begin
      // start (even with an invalid op) has priority over mthi/mtlo.
      if (we == MD_WHI) hi <= src_a;
      if (we == MD_WLO) lo <= src_a;
    end
  end

  always_comb begin
    rd_data = '0;
    if (re == MD_RHI) rd_data = hi;
    if (re == MD_RLO) rd_data = lo;
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [1:0]   we = 2'd0;
  logic [1:0]   re = 2'd0;
  logic         busy;
  logic [W-1:0] rd_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .MULT_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .we      (we),
    .re      (re),
    .busy    (busy),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             len_q[$];
  int             checks = 0;
  int             passes = 0;
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: straight arithmetic on wide integers.
  function automatic logic [2*W-1:0] ref_md(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] h0,
                                            input logic [W-1:0] l0);
    longint sa, sb, q, r;
    logic [2*W-1:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      MD_MULT:  begin q = sa * sb; return q; end
      MD_MULTU: begin u = {32'd0, a} * {32'd0, b}; return u; end
      MD_DIV: begin
        if (b == 0) return {h0, l0};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {h0, l0};
        return {a % b, a / b};
      end
      default: return {h0, l0};
    endcase
  endfunction

  // ---------------- monitor ----------------
  int   busy_len = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          logic [2*W-1:0] e;
          int             n;
          e = exp_q.pop_front();
          n = len_q.pop_front();
          chk("result_hilo", {hi, lo}, e);
          chk("busy_cycles", 64'(busy_len), 64'(n));
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    e = ref_md(o, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    len_q.push_back((o == MD_MULT || o == MD_MULTU) ? MULN : DIVN);
    {m_hi, m_lo} = e;
    @(negedge clk);
    start = 1'b0;
    op    = MD_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    @(negedge clk);
  endtask

  task automatic mt_write(input logic [1:0] w, input logic [W-1:0] v);
    we    = w;
    src_a = v;
    @(negedge clk);
    we = MD_WNONE;
    if (w == MD_WHI) m_hi = v;
    if (w == MD_WLO) m_lo = v;
  endtask

  task automatic read_chk(input string name, input logic [1:0] r, input logic [W-1:0] e);
    re = r;
    #1;
    chk(name, {32'd0, rd_data}, {32'd0, e});
    re = MD_RNONE;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] old_lo;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    read_chk("reset_rd_hi", MD_RHI, 32'd0);

    // directed cases
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    chk("mult_model", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    read_chk("mflo_after_mult", MD_RLO, 32'hFFFF_FFEB);

    launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    read_chk("mfhi_after_multu", MD_RHI, 32'h0000_0001);

    launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_model", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("div_ovf_model", {m_hi, m_lo}, 64'h0000_0000_8000_0000);

    mt_write(MD_WHI, 32'h11);
    mt_write(MD_WLO, 32'h22);
    read_chk("mthi", MD_RHI, 32'h11);
    read_chk("mtlo", MD_RLO, 32'h22);
    launch(MD_DIVU, 32'd9, 32'd0);
    wait_idle();
    chk("divu0_model", {m_hi, m_lo}, 64'h0000_0011_0000_0022);

    // interference while a mult runs
    old_lo = m_lo;
    launch(MD_MULT, 32'd1234, 32'hFFFF_FF00);
    start = 1'b1; op = MD_DIVU; src_a = 32'd77; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    we = MD_WLO; src_a = 32'h55;
    @(negedge clk);
    we = MD_WNONE; src_a = 32'hDEAD_BEEF;
    read_chk("mflo_during_busy", MD_RLO, old_lo);
    wait_idle();
    read_chk("mflo_after_interference", MD_RLO, m_lo);

    // start with invalid op beats mthi; we=3 is a no-op
    start = 1'b1; op = 3'd5; we = MD_WHI; src_a = 32'h1234;
    @(negedge clk);
    start = 1'b0; op = MD_NONE; we = MD_WNONE;
    chk("invalid_op_busy", {63'd0, busy}, 64'd0);
    chk("invalid_op_hilo", {hi, lo}, {m_hi, m_lo});
    start = 1'b1; op = MD_NONE; we = MD_WLO;
    @(negedge clk);
    start = 1'b0; we = 2'd3; src_a = 32'h9999;
    @(negedge clk);
    we = MD_WNONE;
    chk("noop_writes_hilo", {hi, lo}, {m_hi, m_lo});

    // randomized ops
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) mt_write(MD_WHI, $urandom);
      if ($urandom_range(0, 3) == 0) mt_write(MD_WLO, $urandom);
      launch(ro, ra, rb);
      wait_idle();
      read_chk("rand_mfhi", MD_RHI, m_hi);
    end

    // asynchronous reset mid-divide, at cnt==2
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (DIVN - 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midop_reset_busy", {63'd0, busy}, 64'd0);
    chk("midop_reset_hilo", {hi, lo}, 64'd0);
    exp_q.delete();
    len_q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", {63'd0, busy}, 64'd0);
    mt_write(MD_WHI, 32'hABCD);
    read_chk("mthi_after_reset", MD_RHI, 32'hABCD);
    read_chk("lo_after_reset", MD_RLO, 32'd0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit owning the HI/LO registers for the pipelined MIPS core.
- Sits in the EX stage and is driven by the decoder's multctrl, start, muwe and mure outputs.
- Generalises the fixed mult/div block:
  - operand width is configurable;
  - multiply and divide latencies are independently configurable;
  - a registered busy is provided for stall generation;
  - divide-by-zero and signed-overflow behaviour is defined.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be >= 1.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch operation selected by op.
- op  in  3  operation code: 1 mult, 2 multu, 3 div, 4 divu, 0 none.
- src_a  in  WIDTH  rs value.
- src_b  in  WIDTH  rt value.
- we  in  2  register write: 1 mthi, 2 mtlo, 0 none.
- re  in  2  register read: 1 mfhi, 2 mflo, 0 none.
- busy  out  1  operation in flight.
- rd_data  out  WIDTH  read data for mfhi/mflo.
- hi  out  WIDTH  current HI.
- lo  out  WIDTH  current LO.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-operation):
  - hi=0, lo=0, busy=0, counter=0.
  - Captured operands and op cleared.
  - No pending result survives reset.
- Idle is busy=0. Running is busy=1, with a down-counter cnt.
- Launch:
  - Condition: rising edge with start=1, busy=0, op in 1..4.
  - Latch src_a, src_b and op.
  - cnt <= MULT_CYCLES or DIV_CYCLES according to op; busy <= 1.
- Launch with start=1 and op=0 or op>4: no effect.
- While busy=1:
  - Each edge decrements cnt.
  - On the edge where cnt==1, write hi/lo from the latched operands, set cnt <= 0 and busy <= 0.
  - busy is therefore high for exactly N cycles; hi/lo show the new result from the same edge that drops busy.
- start while busy=1: ignored. Upstream stall logic must hold the instruction.
- Results:
  - mult: {hi,lo} = signed(a) * signed(b), full 2*WIDTH product.
  - multu: {hi,lo} = unsigned product.
  - div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - div with a = most-negative and b = -1: lo = a (wrap), hi = 0.
  - divu: unsigned quotient and remainder.
  - div or divu with b=0: hi and lo retain their prior values; busy still runs DIV_CYCLES.
- we (mthi/mtlo):
  - Applied on the edge only when busy=0 and start=0.
  - Ignored when busy=1.
  - Ignored when start=1 in the same cycle (start has priority).
  - we=3 is treated as none.
- rd_data is combinational:
  - re=1 gives hi; re=2 gives lo; otherwise 0.
  - While busy=1, rd_data returns the pre-operation value. Upstream stalls mf* on busy.
- Operands are captured at launch. Changes to src_a/src_b during busy have no effect.

Decomposition:
- Shared constants go in the common header alongside the decoder opcodes:
  - MD op codes: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - we encodings: MD_WHI, MD_WLO.
  - re encodings: MD_RHI, MD_RLO.
- One sub-module, md_arith: combinational, WIDTH-parametrised. It takes the latched a, b and op and produces res_hi, res_lo and div0.
- md_unit keeps the counter, the registers and the write-priority logic.

Test Plan:
- mult with a=-3 (0xFFFFFFFD), b=7 → busy high exactly 5 cycles → hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy falls on the same edge.
- multu with a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- div with a=-7, b=2 → busy 10 cycles → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div with a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- divu with a=9, b=0, after mthi 0x11 and mtlo 0x22 → busy 10 cycles → hi=0x11, lo=0x22 unchanged.
- During a running mult:
  - second start, mtlo 0x55 and changed src_a all ignored;
  - re=2 returns the old lo;
  - after busy drops, lo equals the original product.
- Assert reset=0 at cnt==2 of a div → busy=0 and hi=lo=0 immediately. Release, issue mthi 0xABCD → re=1 gives 0xABCD.
